// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
// Imported by the picker and the arbiter top.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = idx_w(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port
// between N_REQ producers; writes are gated by FIFO_FULL.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
)(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          REQ_LAST,
  input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]          GNT,
  input  logic                      FIFO_FULL,
  output logic                      FIFO_WR_EN,
  output logic [DATA_W-1:0]         FIFO_DATA_IN,
  output logic                      BUSY,
  output logic [idx_w(N_REQ)-1:0]   OWNER
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          in_grant;
  logic          own_req;
  logic          own_last;
  logic          beat;
  logic [IW-1:0] next_ptr;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req   (REQ),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign in_grant = (state_q == GRANT);
  assign own_req  = REQ[owner_q];
  assign own_last = REQ_LAST[owner_q];
  assign beat     = in_grant && own_req && !FIFO_FULL;
  assign next_ptr = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    GNT          = '0;
    FIFO_WR_EN   = 1'b0;
    FIFO_DATA_IN = '0;
    if (in_grant) begin
      GNT[owner_q] = !FIFO_FULL;
      FIFO_WR_EN   = beat;
      FIFO_DATA_IN = REQ_DATA[int'(owner_q)*DATA_W +: DATA_W];
    end
  end

  assign BUSY  = in_grant;
  assign OWNER = owner_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!own_req) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (own_last ||
              beat_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
